// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// ALUOp and mux selects, plus the internal control word.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction/flag inputs and all control outputs.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, state
    );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational control word for each state; mem_ready is the only Mealy
// qualifier (FETCH strobes wait for the instruction to arrive).
module mc_output_decode
    import multicycle_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // State to control-word table; unlisted fields stay zero.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_JEX: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register, opcode-driven sequencing
// and PC enable; outputs are forced to zero while reset is high.
module multicycle_control
    import multicycle_pkg::*;
(
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master bus
);

    state_e state_r;
    state_e state_next_s;
    ctrl_t  ctrl_s;
    ctrl_t  ctrl_gated_s;

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state sequencing; the opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (bus.mem_ready) state_next_s = S_DECODE;
                else               state_next_s = S_FETCH;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next_s = S_MEMADR;
                    OP_RTYPE:     state_next_s = S_REXEC;
                    OP_BEQ:       state_next_s = S_BEQEX;
                    OP_ADDI:      state_next_s = S_ADDIEX;
                    OP_J:         state_next_s = S_JEX;
                    default:      state_next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // An opcode that changed under us is dropped rather than guessed at.
                if (bus.opcode == OP_LW)      state_next_s = S_MEMRD;
                else if (bus.opcode == OP_SW) state_next_s = S_MEMWR;
                else                          state_next_s = S_FETCH;
            end
            S_MEMRD: begin
                if (bus.mem_ready) state_next_s = S_MEMWB;
                else               state_next_s = S_MEMRD;
            end
            S_MEMWR: begin
                if (bus.mem_ready) state_next_s = S_FETCH;
                else               state_next_s = S_MEMWR;
            end
            S_REXEC:  state_next_s = S_RWB;
            S_ADDIEX: state_next_s = S_ADDIWB;
            default:  state_next_s = S_FETCH;
        endcase
    end

    mc_output_decode u_output_decode (
        .state     (state_r),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl_s)
    );

    assign ctrl_gated_s   = reset ? ctrl_t'('0) : ctrl_s;

    assign bus.alu_op     = ctrl_gated_s.alu_op;
    assign bus.alu_src_a  = ctrl_gated_s.alu_src_a;
    assign bus.alu_src_b  = ctrl_gated_s.alu_src_b;
    assign bus.pc_src     = ctrl_gated_s.pc_src;
    assign bus.pc_en      = ctrl_gated_s.pc_write | (ctrl_gated_s.branch & bus.zero);
    assign bus.iord       = ctrl_gated_s.iord;
    assign bus.mem_write  = ctrl_gated_s.mem_write;
    assign bus.ir_write   = ctrl_gated_s.ir_write;
    assign bus.reg_write  = ctrl_gated_s.reg_write;
    assign bus.reg_dst    = ctrl_gated_s.reg_dst;
    assign bus.mem_to_reg = ctrl_gated_s.mem_to_reg;
    assign bus.state      = reset ? 4'd0 : state_r;

endmodule
